// File: rtl/scan_mux_pkg.sv
// Shared constants for scan_mux: mode encoding and default geometry.
package scan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_SCAN  = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 4;

endpackage

// File: rtl/scan_mux_sel.sv
// Combinational NCH-to-1 channel select; out-of-range indices fall back to channel 0.
module scan_mux_sel #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic [NCH*WIDTH-1:0] data,
    input  logic [SELW-1:0]      idx,
    output logic [WIDTH-1:0]     d,
    output logic [SELW-1:0]      ch
);

    // Only legal channels can match, so an index >= NCH keeps the channel-0 default.
    always_comb begin
        d  = data[0 +: WIDTH];
        ch = '0;
        for (int k = 1; k < NCH; k++) begin
            if (idx == SELW'(k)) begin
                d  = data[k*WIDTH +: WIDTH];
                ch = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered channel mux with fixed/round-robin scan modes and valid/ready output handshake.
// Optional registered even parity on y when SCAN_MUX_PARITY_EN is defined.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 in_en,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch,
    output logic                 y_valid,
    output logic                 y_par
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  idx;
    logic [SELW-1:0]  cap_ch;
    logic [WIDTH-1:0] cap_d;
    logic             capture;

    assign idx     = (mode == MODE_SCAN) ? ptr : sel;
    assign capture = in_en && (!y_valid || out_ready);

    scan_mux_sel #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW)
    ) u_sel (
        .data (in_data),
        .idx  (idx),
        .d    (cap_d),
        .ch   (cap_ch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            ptr     <= '0;
        end else begin
            if (capture) begin
                y       <= cap_d;
                y_ch    <= cap_ch;
                y_valid <= 1'b1;
            end else if (out_ready) begin
                y_valid <= 1'b0;
            end
            // Advance from the channel actually used, so an out-of-range pointer restarts at 1.
            if (mode == MODE_FIXED)
                ptr <= sel;
            else if (capture)
                ptr <= (cap_ch == SELW'(NCH-1)) ? '0 : cap_ch + SELW'(1);
        end
    end

`ifdef SCAN_MUX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_q <= 1'b0;
        else if (capture)
            par_q <= ^cap_d;
    end

    assign y_par = par_q;
`else
    assign y_par = 1'b0;
`endif

endmodule
